// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution unit: funct3 codes, queue depth
// and the result record carried through the output queue.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int QUEUE_DEPTH = 2;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] linkAddr;
        logic        misaligned;
        logic        illegal;
    } branch_result_t;

    // jalr clears bit 0 of the computed address
    function automatic logic [31:0] jalr_align(input logic [31:0] sum);
        return {sum[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: maps subtraction flags, funct3
// and jump qualifiers to the taken / illegal decision.
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       isJal_i,
    input  logic       isJalr_i,
    input  logic       zero_i,
    input  logic       carryOut_i,
    input  logic       negative_i,
    input  logic       overflow_i,
    output logic       taken_o,
    output logic       illegal_o
);

    logic lt_signed;

    assign lt_signed = negative_i ^ overflow_i;

    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        if (isJal_i || isJalr_i) begin
            taken_o = 1'b1;
        end else begin
            // carryOut of rs1 - rs2 is set when no borrow, i.e. rs1 >= rs2 unsigned
            case (funct3_i)
                F3_BEQ:  taken_o = zero_i;
                F3_BNE:  taken_o = ~zero_i;
                F3_BLT:  taken_o = lt_signed;
                F3_BGE:  taken_o = ~lt_signed;
                F3_BLTU: taken_o = ~carryOut_i;
                F3_BGEU: taken_o = carryOut_i;
                default: illegal_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Branch/jump resolution with a 2-entry in-order result queue.
// Optional feature macro: BRANCH_UNIT_STATS_EN adds resolvedCount/takenCount.
module branch_unit
    import branch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        inValid,
    output logic        inReady,
    input  logic [2:0]  funct3,
    input  logic        isJal,
    input  logic        isJalr,
    input  logic [31:0] pc,
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic        zero,
    input  logic        carryOut,
    input  logic        negative,
    input  logic        overflow,
    output logic        outValid,
    input  logic        outReady,
    output logic        taken,
    output logic [31:0] target,
    output logic [31:0] linkAddr,
    output logic        misaligned,
    output logic        illegal
`ifdef BRANCH_UNIT_STATS_EN
   ,output logic [31:0] resolvedCount,
    output logic [31:0] takenCount
`endif
);

    logic           cond_taken;
    logic           cond_illegal;
    logic [31:0]    new_target;
    branch_result_t new_res;

    logic [1:0]     count_q, count_d;
    branch_result_t head_q, head_d;
    branch_result_t tail_q, tail_d;
    logic           push;
    logic           pop;

    branch_cond u_cond (
        .funct3_i   (funct3),
        .isJal_i    (isJal),
        .isJalr_i   (isJalr),
        .zero_i     (zero),
        .carryOut_i (carryOut),
        .negative_i (negative),
        .overflow_i (overflow),
        .taken_o    (cond_taken),
        .illegal_o  (cond_illegal)
    );

    assign new_target = isJalr ? jalr_align(base + imm) : (pc + imm);

    always_comb begin
        new_res.taken      = cond_taken;
        new_res.target     = new_target;
        new_res.linkAddr   = pc + 32'd4;
        new_res.misaligned = cond_taken & new_target[1];
        new_res.illegal    = cond_illegal;
    end

    // inReady depends only on the registered count, never on outReady
    assign inReady  = (count_q < 2'(QUEUE_DEPTH));
    assign outValid = (count_q != 2'd0);
    assign push     = inValid && inReady;
    assign pop      = outValid && outReady;

    // head_q is always the oldest entry; tail_q holds the second when full
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = new_res;
                    end else begin
                        tail_d = new_res;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // push implies count_q == 1 here, so the new beat becomes head
                    head_d = new_res;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign taken      = head_q.taken;
    assign target     = head_q.target;
    assign linkAddr   = head_q.linkAddr;
    assign misaligned = head_q.misaligned;
    assign illegal    = head_q.illegal;

`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] resolved_q, resolved_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;

    // flush suppresses the pop, so a flushed head is not counted
    always_comb begin
        resolved_d  = resolved_q;
        taken_cnt_d = taken_cnt_q;
        if (pop && !flush) begin
            resolved_d = resolved_q + 32'd1;
            if (head_q.taken) begin
                taken_cnt_d = taken_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resolved_q  <= 32'd0;
            taken_cnt_q <= 32'd0;
        end else begin
            resolved_q  <= resolved_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign resolvedCount = resolved_q;
    assign takenCount    = taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed literal cases plus randomized traffic checked
// against a queue-based model that resolves branches from the rs1/rs2 values.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst, flush, inValid, inReady, isJal, isJalr;
    logic [2:0]  funct3;
    logic [31:0] pc, base, imm;
    logic        zero, carryOut, negative, overflow;
    logic        outValid, outReady, taken, misaligned, illegal;
    logic [31:0] target, linkAddr;
`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] resolvedCount, takenCount;
`endif

    always #5 clk = ~clk;

    branch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .inValid    (inValid),
        .inReady    (inReady),
        .funct3     (funct3),
        .isJal      (isJal),
        .isJalr     (isJalr),
        .pc         (pc),
        .base       (base),
        .imm        (imm),
        .zero       (zero),
        .carryOut   (carryOut),
        .negative   (negative),
        .overflow   (overflow),
        .outValid   (outValid),
        .outReady   (outReady),
        .taken      (taken),
        .target     (target),
        .linkAddr   (linkAddr),
        .misaligned (misaligned),
        .illegal    (illegal)
`ifdef BRANCH_UNIT_STATS_EN
       ,.resolvedCount (resolvedCount),
        .takenCount    (takenCount)
`endif
    );

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          model_live = 0;
    bit          zeroed = 0;
    logic [31:0] cur_rs1 = 0, cur_rs2 = 0;
    logic [31:0] m_resolved = 0, m_taken = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: resolve the branch directly from the operand values
    function automatic exp_t calc(input logic [2:0] f3, input logic jal, input logic jalr,
                                  input logic [31:0] p, input logic [31:0] b,
                                  input logic [31:0] im, input logic [31:0] a,
                                  input logic [31:0] c);
        exp_t e;
        e.link = p + 32'd4;
        e.ill  = 1'b0;
        if (jal || jalr) begin
            e.taken = 1'b1;
        end else begin
            case (f3)
                3'd0:    e.taken = (a == c);
                3'd1:    e.taken = (a != c);
                3'd4:    e.taken = ($signed(a) <  $signed(c));
                3'd5:    e.taken = ($signed(a) >= $signed(c));
                3'd6:    e.taken = (a <  c);
                3'd7:    e.taken = (a >= c);
                default: begin e.taken = 1'b0; e.ill = 1'b1; end
            endcase
        end
        e.target = jalr ? ((b + im) & ~32'h1) : (p + im);
        e.mis    = e.taken && e.target[1];
        return e;
    endfunction

    task automatic set_beat(input logic v, input logic [2:0] f3, input logic jal,
                            input logic jalr, input logic [31:0] p, input logic [31:0] b,
                            input logic [31:0] im, input logic [31:0] a, input logic [31:0] c);
        logic [31:0] d;
        d        = a - c;
        inValid  = v;
        funct3   = f3;
        isJal    = jal;
        isJalr   = jalr;
        pc       = p;
        base     = b;
        imm      = im;
        cur_rs1  = a;
        cur_rs2  = c;
        zero     = (d == 32'd0);
        carryOut = (a >= c);
        negative = d[31];
        overflow = (a[31] != c[31]) && (d[31] != a[31]);
    endtask

    task automatic idle();
        inValid = 1'b0;
    endtask

    task automatic model_step();
        bit do_pop, do_push;
        if (rst) begin
            q.delete();
            zeroed     = 1;
            model_live = 1;
            m_resolved = 0;
            m_taken    = 0;
        end else if (model_live) begin
            if (flush) begin
                q.delete();
            end else begin
                do_pop  = (q.size() > 0) && outReady;
                do_push = inValid && (q.size() < 2);
                if (do_pop) begin
                    m_resolved++;
                    if (q[0].taken) m_taken++;
                    void'(q.pop_front());
                end
                if (do_push) begin
                    q.push_back(calc(funct3, isJal, isJalr, pc, base, imm, cur_rs1, cur_rs2));
                    zeroed = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            chk("outValid", {31'd0, outValid}, {31'd0, q.size() > 0});
            chk("inReady", {31'd0, inReady}, {31'd0, q.size() < 2});
            if (q.size() > 0) begin
                chk("taken", {31'd0, taken}, {31'd0, q[0].taken});
                chk("target", target, q[0].target);
                chk("linkAddr", linkAddr, q[0].link);
                chk("misaligned", {31'd0, misaligned}, {31'd0, q[0].mis});
                chk("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
            end else if (zeroed) begin
                chk("rst_target", target, 32'd0);
                chk("rst_link", linkAddr, 32'd0);
                chk("rst_flags", {29'd0, taken, misaligned, illegal}, 32'd0);
            end
`ifdef BRANCH_UNIT_STATS_EN
            chk("resolvedCount", resolvedCount, m_resolved);
            chk("takenCount", takenCount, m_taken);
`endif
        end
    end

    initial begin
        rst = 1'b1; flush = 1'b0; outReady = 1'b0;
        set_beat(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        tick(); tick();
        rst = 1'b0;

        chk("lit_rst_outValid", {31'd0, outValid}, 32'd0);
        chk("lit_rst_inReady", {31'd0, inReady}, 32'd1);
        chk("lit_rst_taken", {31'd0, taken}, 32'd0);
        chk("lit_rst_target", target, 32'd0);
        chk("lit_rst_link", linkAddr, 32'd0);
        chk("lit_rst_mis", {31'd0, misaligned}, 32'd0);
        chk("lit_rst_ill", {31'd0, illegal}, 32'd0);

        // BEQ taken, latency 1
        outReady = 1'b1;
        set_beat(1'b1, 3'd0, 1'b0, 1'b0, 32'h100, 32'd0, 32'h20, 32'd7, 32'd7);
        tick();
        chk("lit_beq_valid", {31'd0, outValid}, 32'd1);
        chk("lit_beq_taken", {31'd0, taken}, 32'd1);
        chk("lit_beq_target", target, 32'h120);
        chk("lit_beq_link", linkAddr, 32'h104);

        // BLTU with carryOut=1, BLT with N=V=1, BGE with N=V=1
        set_beat(1'b1, 3'd6, 1'b0, 1'b0, 32'h140, 32'd0, 32'h8, 32'd5, 32'd3);
        tick();
        chk("lit_bltu_taken", {31'd0, taken}, 32'd0);
        set_beat(1'b1, 3'd4, 1'b0, 1'b0, 32'h144, 32'd0, 32'h8, 32'h7fffffff, 32'hffffffff);
        tick();
        chk("lit_blt_taken", {31'd0, taken}, 32'd0);
        set_beat(1'b1, 3'd5, 1'b0, 1'b0, 32'h148, 32'd0, 32'h8, 32'h7fffffff, 32'hffffffff);
        tick();
        chk("lit_bge_taken", {31'd0, taken}, 32'd1);
        idle(); tick();

        // jalr misaligned target
        set_beat(1'b1, 3'd0, 1'b0, 1'b1, 32'h500, 32'h1003, 32'h4, 32'd1, 32'd2);
        tick(); idle();
        chk("lit_jalr_taken", {31'd0, taken}, 32'd1);
        chk("lit_jalr_target", target, 32'h1006);
        chk("lit_jalr_mis", {31'd0, misaligned}, 32'd1);
        chk("lit_jalr_ill", {31'd0, illegal}, 32'd0);
        tick();

        // Backpressure: three beats, third held until space frees
        outReady = 1'b0;
        set_beat(1'b1, 3'd0, 1'b0, 1'b0, 32'h200, 32'd0, 32'h8, 32'd1, 32'd2);
        tick();
        chk("lit_bp_ready1", {31'd0, inReady}, 32'd1);
        set_beat(1'b1, 3'd0, 1'b0, 1'b0, 32'h300, 32'd0, 32'h10, 32'd1, 32'd2);
        tick();
        chk("lit_bp_ready2", {31'd0, inReady}, 32'd0);
        set_beat(1'b1, 3'd0, 1'b0, 1'b0, 32'h400, 32'd0, 32'h40, 32'd1, 32'd2);
        tick();
        chk("lit_bp_hold", linkAddr, 32'h204);
        chk("lit_bp_ready3", {31'd0, inReady}, 32'd0);
        outReady = 1'b1;
        tick();
        chk("lit_bp_second", linkAddr, 32'h304);
        tick(); idle();
        chk("lit_bp_third", linkAddr, 32'h404);
        chk("lit_bp_third_tgt", target, 32'h440);
        tick();
        chk("lit_bp_drained", {31'd0, outValid}, 32'd0);

        // Flush with a full queue and a same-cycle beat
        outReady = 1'b0;
        set_beat(1'b1, 3'd1, 1'b0, 1'b0, 32'h600, 32'd0, 32'h4, 32'd1, 32'd2);
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; idle();
        chk("lit_flush_valid", {31'd0, outValid}, 32'd0);
        chk("lit_flush_ready", {31'd0, inReady}, 32'd1);
        tick();
        chk("lit_flush_lost", {31'd0, outValid}, 32'd0);

`ifdef BRANCH_UNIT_STATS_EN
        rst = 1'b1; tick(); rst = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_beat(1'b1, 3'd2, 1'b1, 1'b0, 32'h700 + i * 4, 32'd0, 32'h10, 32'd0, 32'd0);
            else       set_beat(1'b1, 3'd0, 1'b0, 1'b0, 32'h700 + i * 4, 32'd0, 32'h10, 32'd1, 32'd9);
            tick();
        end
        idle(); tick();
        chk("lit_stat_resolved", resolvedCount, 32'd5);
        chk("lit_stat_taken", takenCount, 32'd3);
        outReady = 1'b0;
        set_beat(1'b1, 3'd7, 1'b1, 1'b0, 32'h800, 32'd0, 32'h10, 32'd0, 32'd0);
        tick(); idle();
        flush = 1'b1; outReady = 1'b1; tick(); flush = 1'b0;
        chk("lit_stat_flush_res", resolvedCount, 32'd5);
        chk("lit_stat_flush_tkn", takenCount, 32'd3);
`endif

        // Randomized traffic checked by the compare process
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] a, c, im;
            a  = $urandom;
            case ($urandom % 4)
                0:       c = a;
                1:       c = a ^ 32'h80000000;
                default: c = $urandom;
            endcase
            im = ($urandom % 2 == 0) ? ($urandom & 32'hfffffffc) : $urandom;
            rst      = ($urandom % 200) == 0;
            flush    = ($urandom % 25) == 0;
            outReady = ($urandom % 10) < 6;
            set_beat(($urandom % 10) < 7, 3'($urandom), ($urandom % 8) == 0,
                     ($urandom % 8) == 0, $urandom, $urandom, im, a, c);
            tick();
        end
        rst = 1'b0; flush = 1'b0; idle(); outReady = 1'b1;
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
# branch_unit

Resolves conditional branches and jumps for the RV32I core. It consumes the ALU's subtraction flags (zero, carry-out, negative, overflow) together with the branch's funct3 and addresses, then computes the taken decision and the redirect target. Results are buffered in a 2-entry output queue behind a valid/ready handshake, which feeds the fetch-redirect logic. It sits between the execute stage and the PC-select path.

## Interface
- No parameters; all widths are fixed at 32-bit RV32.
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- flush  input  1  discards buffered results and the input beat of the same cycle
- inValid  input  1  request beat valid
- inReady  output  1  unit can accept a beat
- funct3  input  3  branch condition code
- isJal  input  1  unconditional PC-relative jump
- isJalr  input  1  unconditional register-relative jump
- pc  input  32  address of the branch instruction
- base  input  32  rs1 value, used for jalr only
- imm  input  32  sign-extended offset
- zero, carryOut, negative, overflow  input  1 each  ALU flags from a subtraction rs1 − rs2
- outValid  output  1  result valid
- outReady  input  1  consumer accepts the result
- taken  output  1  redirect required
- target  output  32  redirect address
- linkAddr  output  32  pc + 4
- misaligned  output  1  taken and target[1] = 1
- illegal  output  1  funct3 is 010 or 011 on a non-jump beat

## Operation
- Taken condition by funct3:
  - 000 BEQ: zero
  - 001 BNE: ~zero
  - 100 BLT: negative ^ overflow
  - 101 BGE: ~(negative ^ overflow)
  - 110 BLTU: ~carryOut
  - 111 BGEU: carryOut
  - 010/011: not taken, illegal = 1
- isJal or isJalr forces taken = 1 and illegal = 0, and funct3 is ignored. If both are set, isJalr wins.
- Target:
  - Branch and jal: pc + imm.
  - jalr: (base + imm) & ~32'h1.
  - All sums are modulo 2^32, with wrap-around and no flag.
- linkAddr = pc + 4, modulo 2^32.
- Results are computed combinationally at accept and written into the output queue, which is an in-order FIFO of depth 2.

## Timing
- Reset values: outValid = 0, taken = 0, target = 0, linkAddr = 0, misaligned = 0, illegal = 0, inReady = 1, queue count = 0.
- inReady = (count < 2). It is a function of registered count only, with no combinational path from outReady.
- A beat is accepted on a clk edge with inValid && inReady. The result appears at the outputs on the next cycle, so latency is 1.
- Pop happens on outValid && outReady.
- Push and pop in the same cycle leave count unchanged, and order is preserved.
- While outValid && !outReady, all result outputs hold stable.
- Full condition: count = 2, so inReady = 0. A pop in that cycle does not enable a push in the same cycle.
- flush:
  - Sets count to 0 on the next edge and drops any same-cycle push.
  - outValid = 0 on the following cycle.
  - flush takes priority over push and pop.
- rst mid-operation behaves exactly like flush and also clears the output registers to 0.

## Configuration
- BRANCH_UNIT_STATS_EN: when defined, adds two outputs:
  - resolvedCount (32 bits): increments on every pop.
  - takenCount (32 bits): increments on every pop with taken = 1.
  - Both reset to 0, wrap at 2^32, and are not cleared by flush.
- When the macro is undefined, these ports and their logic are absent.

## Structure
- Package branch_pkg holds:
  - the funct3 constants (F3_BEQ … F3_BGEU);
  - the queue depth constant (2);
  - a packed struct branch_result_t {taken, target, linkAddr, misaligned, illegal}.
- Sub-module branch_cond is a purely combinational evaluator. It maps flags + funct3 + isJal/isJalr to taken/illegal.
- The FIFO and target arithmetic stay in branch_unit.

## Test plan
- BEQ with zero = 1, pc = 0x100, imm = 0x20 → next cycle: outValid = 1, taken = 1, target = 0x120, linkAddr = 0x104.
- BLTU with carryOut = 1, then BLT with negative = 1 and overflow = 1 → both taken = 0. BGE with the same flags → taken = 1.
- jalr with base = 0x1003, imm = 0x4 → target = 0x1006, misaligned = 1, taken = 1.
- Three back-to-back beats with outReady = 0 → inReady drops after the 2nd accept. The 3rd beat is held. Releasing outReady drains the results in order.
- Queue holding 2 entries, flush asserted with inValid = 1 → next cycle outValid = 0, count = 0, and the input beat is lost.
- With the macro defined: 5 pops, 3 of them taken → resolvedCount = 5, takenCount = 3. Counts are unchanged by flush.
